btn_event_classifier: RTL and testbench
=======================================

// Module: btn_event_classifier
// PURPOSE
//  Consumes the clean, synchronized, active-high level from the button debouncer.
//  Classifies each press into single-cycle event pulses: press, release, single click,
//  double click and long press.
//  Sits between the debouncer and the application control logic (mode/menu FSMs).
// PARAMETERS
//  CLK_FREQ_HZ     50_000_000  clock frequency; prescaler = CLK_FREQ_HZ/1000 cycles per ms
//  LONG_PRESS_MS   1000        hold time that turns a press into a long press
//  DOUBLE_GAP_MS   300         max release-to-press gap for the second click of a double
// PORTS
//  clk          in   1  system clock
//  rst          in   1  synchronous, active-high reset
//  db_in        in   1  debounced button level, 1 = pressed; already synchronous to clk
//  evt_press    out  1  1-cycle pulse on each accepted press
//  evt_release  out  1  1-cycle pulse on each accepted release
//  evt_click    out  1  1-cycle pulse: single short click confirmed
//  evt_double   out  1  1-cycle pulse: double click confirmed
//  evt_long     out  1  1-cycle pulse: long-press threshold reached while held
//  busy         out  1  level: FSM not in IDLE
// BEHAVIOUR
//  - One clock, one reset: synchronous, active-high reset (rst).
//  - Reset: all evt_* = 0, busy = 0, state = IDLE, timers = 0, db_q = 1.
//    db_q = 1 means a button held through reset produces no press; it must be released first.
//  - Edge detect: rise = db_in & ~db_q; fall = ~db_in & db_q; db_q <= db_in every cycle.
//  - Timer: prescaler counts 0..CLK_FREQ_HZ/1000-1; elapsed_ms increments on prescaler wrap.
//    elapsed_ms saturates at max(LONG_PRESS_MS, DOUBLE_GAP_MS).
//    Prescaler and elapsed_ms clear on every state change.
//  - Timeout: tmo_long = (elapsed_ms == LONG_PRESS_MS); tmo_gap = (elapsed_ms == DOUBLE_GAP_MS).
//  - FSM states and transitions:
//    IDLE   : rise -> PRESS1, evt_press
//    PRESS1 : fall -> GAP, evt_release
//             tmo_long -> LONG, evt_long
//    GAP    : rise -> PRESS2, evt_press
//             tmo_gap -> IDLE, evt_click
//    PRESS2 : fall -> IDLE, evt_release + evt_double (same cycle)
//             tmo_long -> LONG, evt_long (no evt_double)
//    LONG   : fall -> IDLE, evt_release; no further events while held
//    illegal: -> IDLE
//  - All evt_* are registered.
//    Each pulses for exactly one cycle, in the cycle after the edge that samples the state change.
//  - Simultaneous events: an input edge beats a timeout in the same cycle.
//    PRESS1 fall + tmo_long -> GAP. GAP rise + tmo_gap -> PRESS2.
//  - At most one classification pulse (click/double/long) per gesture.
//    evt_press and evt_release always alternate.
//  - Reset mid-gesture aborts silently: no pulses. A held button must release, then press again.
// STRUCTURE
//  - Package btn_evt_pkg holds the state enum btn_evt_state_t and the MS_PER_TICK helper function.
//  - Sub-module ms_timer holds the prescaler and the saturating elapsed_ms counter.
//    ms_timer ports: clk, rst, clear, elapsed_ms. Widths come from $clog2 of the limits.
//  - Top level holds the edge detector, FSM and registered outputs.
// TESTING  (bench params: CLK_FREQ_HZ=10_000 -> 10 cycles/ms; LONG_PRESS_MS=20; DOUBLE_GAP_MS=5)
//  1 Hold db_in=1 for 50 cycles, release.
//    -> evt_press once, evt_release once, after gap expiry evt_click once; evt_double = evt_long = 0.
//  2 Press 50 cyc, release 20 cyc, press 50 cyc, release.
//    -> 2 press, 2 release; evt_double on the cycle after the second release; no evt_click.
//  3 Hold 300 cycles.
//    -> evt_long exactly once, ~200 cycles after evt_press; on release only evt_release; busy drops.
//  4 Fall in the same cycle as tmo_long in PRESS1.
//    -> evt_release, no evt_long; then evt_click after the gap.
//  5 Hold db_in=1 through reset deassert.
//    -> no events until release then new press; also assert rst during GAP -> no evt_click, busy = 0.
//  6 Second press arriving 60 cycles after release (gap exceeded).
//    -> evt_click for the first press; the second press starts a new gesture.

Source files
------------

// File: rtl/btn_event_classifier_pkg.sv
// Shared types and helpers for the button event classifier.
// Combinational helpers only; no timing or flow control involved.
package btn_evt_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_PRESS1 = 3'd1,
        ST_GAP    = 3'd2,
        ST_PRESS2 = 3'd3,
        ST_LONG   = 3'd4
    } btn_evt_state_t;

    // Clock cycles that make up one millisecond tick, never less than one.
    function automatic int MS_PER_TICK(input int clk_freq_hz);
        return (clk_freq_hz / 1000 < 1) ? 1 : clk_freq_hz / 1000;
    endfunction

    function automatic int max_ms(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/btn_event_classifier_ms_timer.sv
// Millisecond timer: prescaler plus elapsed_ms counter saturating at MAX_MS.
// clear takes effect on the next edge; elapsed_ms steps once per TICK_CYCLES; no backpressure.
module ms_timer #(
    parameter int TICK_CYCLES = 50_000,
    parameter int MAX_MS      = 1000,
    localparam int PW = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1,
    localparam int MW = $clog2(MAX_MS + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clear,
    output logic [MW-1:0] elapsed_ms
);

    logic [PW-1:0] presc;

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            presc      <= '0;
            elapsed_ms <= '0;
        end else if (presc == PW'(TICK_CYCLES - 1)) begin
            presc <= '0;
            if (elapsed_ms != MW'(MAX_MS))
                elapsed_ms <= elapsed_ms + 1'b1;
        end else begin
            presc <= presc + 1'b1;
        end
    end

endmodule

// File: rtl/btn_event_classifier.sv
// Turns a debounced button level into press/release/click/double/long pulses.
// Pulses are registered, one cycle after the sampling edge; no backpressure.
module btn_event_classifier
    import btn_evt_pkg::*;
#(
    parameter int CLK_FREQ_HZ   = 50_000_000,
    parameter int LONG_PRESS_MS = 1000,
    parameter int DOUBLE_GAP_MS = 300
) (
    input  logic clk,
    input  logic rst,
    input  logic db_in,
    output logic evt_press,
    output logic evt_release,
    output logic evt_click,
    output logic evt_double,
    output logic evt_long,
    output logic busy
);

    localparam int MAX_MS = max_ms(LONG_PRESS_MS, DOUBLE_GAP_MS);
    localparam int MW     = $clog2(MAX_MS + 1);

    btn_evt_state_t state, state_nxt;
    logic           db_q;
    logic           rise, fall;
    logic           clear;
    logic [MW-1:0]  elapsed_ms;
    logic           tmo_long, tmo_gap;
    logic           press_nxt, release_nxt, click_nxt, double_nxt, long_nxt;

    assign rise     = db_in & ~db_q;
    assign fall     = ~db_in & db_q;
    assign tmo_long = (elapsed_ms == MW'(LONG_PRESS_MS));
    assign tmo_gap  = (elapsed_ms == MW'(DOUBLE_GAP_MS));
    assign clear    = (state_nxt != state);
    assign busy     = (state != ST_IDLE);

    ms_timer #(
        .TICK_CYCLES (MS_PER_TICK(CLK_FREQ_HZ)),
        .MAX_MS      (MAX_MS)
    ) u_timer (
        .clk        (clk),
        .rst        (rst),
        .clear      (clear),
        .elapsed_ms (elapsed_ms)
    );

    // Edges are tested before timeouts so a coincident edge always wins.
    always_comb begin
        state_nxt   = state;
        press_nxt   = 1'b0;
        release_nxt = 1'b0;
        click_nxt   = 1'b0;
        double_nxt  = 1'b0;
        long_nxt    = 1'b0;
        case (state)
            ST_IDLE: begin
                if (rise) begin
                    state_nxt = ST_PRESS1;
                    press_nxt = 1'b1;
                end
            end
            ST_PRESS1: begin
                if (fall) begin
                    state_nxt   = ST_GAP;
                    release_nxt = 1'b1;
                end else if (tmo_long) begin
                    state_nxt = ST_LONG;
                    long_nxt  = 1'b1;
                end
            end
            ST_GAP: begin
                if (rise) begin
                    state_nxt = ST_PRESS2;
                    press_nxt = 1'b1;
                end else if (tmo_gap) begin
                    state_nxt = ST_IDLE;
                    click_nxt = 1'b1;
                end
            end
            ST_PRESS2: begin
                if (fall) begin
                    state_nxt   = ST_IDLE;
                    release_nxt = 1'b1;
                    double_nxt  = 1'b1;
                end else if (tmo_long) begin
                    state_nxt = ST_LONG;
                    long_nxt  = 1'b1;
                end
            end
            ST_LONG: begin
                if (fall) begin
                    state_nxt   = ST_IDLE;
                    release_nxt = 1'b1;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // db_q resets high so a button held through reset must be released first.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_IDLE;
            db_q        <= 1'b1;
            evt_press   <= 1'b0;
            evt_release <= 1'b0;
            evt_click   <= 1'b0;
            evt_double  <= 1'b0;
            evt_long    <= 1'b0;
        end else begin
            state       <= state_nxt;
            db_q        <= db_in;
            evt_press   <= press_nxt;
            evt_release <= release_nxt;
            evt_click   <= click_nxt;
            evt_double  <= double_nxt;
            evt_long    <= long_nxt;
        end
    end

endmodule

// File: tb/tb_btn_event_classifier.sv
// Bench for btn_event_classifier at 10 cycles/ms, long = 20 ms, gap = 5 ms.
// Expected events (kind, cycle) are queued at stimulus time and matched against recorded DUT pulses.
module tb_btn_event_classifier;

    localparam int K_PRESS   = 0;
    localparam int K_RELEASE = 1;
    localparam int K_CLICK   = 2;
    localparam int K_DOUBLE  = 3;
    localparam int K_LONG    = 4;

    typedef struct {
        int kind;
        int cyc;
    } ev_t;

    logic clk = 1'b0;
    logic rst;
    logic db_in;
    logic evt_press, evt_release, evt_click, evt_double, evt_long, busy;

    int   ncyc   = 0;
    int   tests  = 0;
    int   fails  = 0;
    int   obs_rd = 0;
    ev_t  exp_q[$];
    ev_t  obs_q[$];

    btn_event_classifier #(
        .CLK_FREQ_HZ   (10_000),
        .LONG_PRESS_MS (20),
        .DOUBLE_GAP_MS (5)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .db_in       (db_in),
        .evt_press   (evt_press),
        .evt_release (evt_release),
        .evt_click   (evt_click),
        .evt_double  (evt_double),
        .evt_long    (evt_long),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) ncyc <= ncyc + 1;

    function automatic ev_t mk_ev(input int kind, input int cyc);
        ev_t e;
        e.kind = kind;
        e.cyc  = cyc;
        return e;
    endfunction

    // Records every pulse seen by the DUT, tagged with the cycle it is visible in.
    always @(negedge clk) begin
        if (evt_press)   obs_q.push_back(mk_ev(K_PRESS, ncyc));
        if (evt_release) obs_q.push_back(mk_ev(K_RELEASE, ncyc));
        if (evt_click)   obs_q.push_back(mk_ev(K_CLICK, ncyc));
        if (evt_double)  obs_q.push_back(mk_ev(K_DOUBLE, ncyc));
        if (evt_long)    obs_q.push_back(mk_ev(K_LONG, ncyc));
    end

    task automatic push_exp(input int kind, input int cyc);
        exp_q.push_back(mk_ev(kind, cyc));
    endtask

    // Drive level v at the current negedge and hold it for n cycles.
    task automatic hold(input logic v, input int n);
        db_in = v;
        repeat (n) @(negedge clk);
    endtask

    task automatic test_reset;
        rst   = 1'b1;
        db_in = 1'b0;
        repeat (3) @(negedge clk);
        tests++; if (evt_press !== 1'b0)   begin fails++; $display("FAIL reset_press: got %b want 0", evt_press); end
        tests++; if (evt_release !== 1'b0) begin fails++; $display("FAIL reset_release: got %b want 0", evt_release); end
        tests++; if (evt_click !== 1'b0)   begin fails++; $display("FAIL reset_click: got %b want 0", evt_click); end
        tests++; if (evt_double !== 1'b0)  begin fails++; $display("FAIL reset_double: got %b want 0", evt_double); end
        tests++; if (evt_long !== 1'b0)    begin fails++; $display("FAIL reset_long: got %b want 0", evt_long); end
        tests++; if (busy !== 1'b0)        begin fails++; $display("FAIL reset_busy: got %b want 0", busy); end
        rst = 1'b0;
        repeat (10) @(negedge clk);
        tests++;
        if (obs_q.size() != 0) begin
            fails++; $display("FAIL reset_quiet: got %0d events want 0", obs_q.size());
        end
        obs_rd = obs_q.size();
    endtask

    task automatic test_single_click;
        string nm = "single_click";
        ev_t   e, o;
        int    k = ncyc;
        push_exp(K_PRESS, k + 1);
        push_exp(K_RELEASE, k + 51);
        push_exp(K_CLICK, k + 102);
        hold(1'b1, 50);
        tests++; if (busy !== 1'b1) begin fails++; $display("FAIL click_busy_held: got %b want 1", busy); end
        hold(1'b0, 80);
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL click_busy_idle: got %b want 0", busy); end
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front(); tests++;
            o = (obs_rd < obs_q.size()) ? obs_q[obs_rd] : mk_ev(-1, -1); obs_rd++;
            if (o.kind !== e.kind || o.cyc !== e.cyc) begin fails++; $display("FAIL %s: got kind %0d @%0d, want kind %0d @%0d", nm, o.kind, o.cyc, e.kind, e.cyc); end
        end
        tests++; if (obs_q.size() > obs_rd) begin fails++; $display("FAIL %s_extra: got %0d events, want %0d", nm, obs_q.size(), obs_rd); end
        obs_rd = obs_q.size();
    endtask

    task automatic test_double_click;
        string nm = "double_click";
        ev_t   e, o;
        int    k = ncyc;
        push_exp(K_PRESS, k + 1);
        push_exp(K_RELEASE, k + 51);
        push_exp(K_PRESS, k + 71);
        push_exp(K_RELEASE, k + 121);
        push_exp(K_DOUBLE, k + 121);
        hold(1'b1, 50);
        hold(1'b0, 20);
        hold(1'b1, 50);
        hold(1'b0, 80);
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front(); tests++;
            o = (obs_rd < obs_q.size()) ? obs_q[obs_rd] : mk_ev(-1, -1); obs_rd++;
            if (o.kind !== e.kind || o.cyc !== e.cyc) begin fails++; $display("FAIL %s: got kind %0d @%0d, want kind %0d @%0d", nm, o.kind, o.cyc, e.kind, e.cyc); end
        end
        tests++; if (obs_q.size() > obs_rd) begin fails++; $display("FAIL %s_extra: got %0d events, want %0d", nm, obs_q.size(), obs_rd); end
        obs_rd = obs_q.size();
    endtask

    task automatic test_long_press;
        string nm = "long_press";
        ev_t   e, o;
        int    k = ncyc;
        push_exp(K_PRESS, k + 1);
        push_exp(K_LONG, k + 202);
        push_exp(K_RELEASE, k + 301);
        hold(1'b1, 300);
        tests++; if (busy !== 1'b1) begin fails++; $display("FAIL long_busy_held: got %b want 1", busy); end
        hold(1'b0, 1);
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL long_busy_drop: got %b want 0", busy); end
        hold(1'b0, 79);
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front(); tests++;
            o = (obs_rd < obs_q.size()) ? obs_q[obs_rd] : mk_ev(-1, -1); obs_rd++;
            if (o.kind !== e.kind || o.cyc !== e.cyc) begin fails++; $display("FAIL %s: got kind %0d @%0d, want kind %0d @%0d", nm, o.kind, o.cyc, e.kind, e.cyc); end
        end
        tests++; if (obs_q.size() > obs_rd) begin fails++; $display("FAIL %s_extra: got %0d events, want %0d", nm, obs_q.size(), obs_rd); end
        obs_rd = obs_q.size();
    endtask

    // Release lands on the very cycle the long-press timeout is reached.
    task automatic test_release_beats_long;
        string nm = "release_beats_long";
        ev_t   e, o;
        int    k = ncyc;
        push_exp(K_PRESS, k + 1);
        push_exp(K_RELEASE, k + 202);
        push_exp(K_CLICK, k + 253);
        hold(1'b1, 201);
        hold(1'b0, 80);
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front(); tests++;
            o = (obs_rd < obs_q.size()) ? obs_q[obs_rd] : mk_ev(-1, -1); obs_rd++;
            if (o.kind !== e.kind || o.cyc !== e.cyc) begin fails++; $display("FAIL %s: got kind %0d @%0d, want kind %0d @%0d", nm, o.kind, o.cyc, e.kind, e.cyc); end
        end
        tests++; if (obs_q.size() > obs_rd) begin fails++; $display("FAIL %s_extra: got %0d events, want %0d", nm, obs_q.size(), obs_rd); end
        obs_rd = obs_q.size();
    endtask

    // Second press lands on the very cycle the gap timeout is reached.
    task automatic test_press_beats_gap;
        string nm = "press_beats_gap";
        ev_t   e, o;
        int    k = ncyc;
        push_exp(K_PRESS, k + 1);
        push_exp(K_RELEASE, k + 31);
        push_exp(K_PRESS, k + 82);
        push_exp(K_RELEASE, k + 112);
        push_exp(K_DOUBLE, k + 112);
        hold(1'b1, 30);
        hold(1'b0, 51);
        hold(1'b1, 30);
        hold(1'b0, 80);
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front(); tests++;
            o = (obs_rd < obs_q.size()) ? obs_q[obs_rd] : mk_ev(-1, -1); obs_rd++;
            if (o.kind !== e.kind || o.cyc !== e.cyc) begin fails++; $display("FAIL %s: got kind %0d @%0d, want kind %0d @%0d", nm, o.kind, o.cyc, e.kind, e.cyc); end
        end
        tests++; if (obs_q.size() > obs_rd) begin fails++; $display("FAIL %s_extra: got %0d events, want %0d", nm, obs_q.size(), obs_rd); end
        obs_rd = obs_q.size();
    endtask

    task automatic test_gap_expired;
        string nm = "gap_expired";
        ev_t   e, o;
        int    k = ncyc;
        push_exp(K_PRESS, k + 1);
        push_exp(K_RELEASE, k + 51);
        push_exp(K_CLICK, k + 102);
        push_exp(K_PRESS, k + 111);
        push_exp(K_RELEASE, k + 141);
        push_exp(K_CLICK, k + 192);
        hold(1'b1, 50);
        hold(1'b0, 60);
        hold(1'b1, 30);
        hold(1'b0, 80);
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front(); tests++;
            o = (obs_rd < obs_q.size()) ? obs_q[obs_rd] : mk_ev(-1, -1); obs_rd++;
            if (o.kind !== e.kind || o.cyc !== e.cyc) begin fails++; $display("FAIL %s: got kind %0d @%0d, want kind %0d @%0d", nm, o.kind, o.cyc, e.kind, e.cyc); end
        end
        tests++; if (obs_q.size() > obs_rd) begin fails++; $display("FAIL %s_extra: got %0d events, want %0d", nm, obs_q.size(), obs_rd); end
        obs_rd = obs_q.size();
    endtask

    task automatic test_reset_mid_gesture;
        string nm = "reset_mid_gesture";
        ev_t   e, o;
        int    k;
        rst   = 1'b1;
        db_in = 1'b1;
        repeat (5) @(negedge clk);
        rst = 1'b0;
        hold(1'b1, 40);
        hold(1'b0, 20);
        k = ncyc;
        push_exp(K_PRESS, k + 1);
        push_exp(K_RELEASE, k + 31);
        hold(1'b1, 30);
        hold(1'b0, 10);
        tests++; if (busy !== 1'b1) begin fails++; $display("FAIL rst_gap_busy_before: got %b want 1", busy); end
        rst = 1'b1;
        repeat (3) @(negedge clk);
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL rst_gap_busy_after: got %b want 0", busy); end
        rst = 1'b0;
        hold(1'b0, 80);
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL rst_gap_busy_idle: got %b want 0", busy); end
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front(); tests++;
            o = (obs_rd < obs_q.size()) ? obs_q[obs_rd] : mk_ev(-1, -1); obs_rd++;
            if (o.kind !== e.kind || o.cyc !== e.cyc) begin fails++; $display("FAIL %s: got kind %0d @%0d, want kind %0d @%0d", nm, o.kind, o.cyc, e.kind, e.cyc); end
        end
        tests++; if (obs_q.size() > obs_rd) begin fails++; $display("FAIL %s_extra: got %0d events, want %0d", nm, obs_q.size(), obs_rd); end
        obs_rd = obs_q.size();
    endtask

    initial begin
        rst   = 1'b1;
        db_in = 1'b0;
        @(negedge clk);
        test_reset();
        test_single_click();
        test_double_click();
        test_long_press();
        test_release_beats_long();
        test_press_beats_gap();
        test_gap_expired();
        test_reset_mid_gesture();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
